// File: rtl/uart_cfg_rx.sv
// Oversampled 8N1 UART receiver: each received byte becomes a held
// address/data request (upper/lower nibble) that is released by ack.
module uart_cfg_rx #(
   parameter int OVERSAMPLE = 16,
   parameter int MID_SAMPLE = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_16bd,
   input  logic       rx,
   input  logic       ack,
   output logic [3:0] address,
   output logic [3:0] data,
   output logic       valid,
   output logic       busy,
   output logic       frame_err,
   output logic       overrun
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] MID_LAST = CW'(MID_SAMPLE - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            rx_meta_q, rx_s_q, rx_prev_q;
   logic            clk_16bd_q;
   logic [3:0]      address_q, address_d, data_q, data_d;
   logic            valid_q, valid_d;
   logic            frame_err_q, frame_err_d;
   logic            overrun_q, overrun_d;
   logic            tick, byte_done;

   assign tick = clk_16bd & ~clk_16bd_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_prev_q   <= 1'b1;
         clk_16bd_q  <= 1'b0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         address_q   <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rx_meta_q   <= rx;
         rx_s_q      <= rx_meta_q;
         rx_prev_q   <= rx_s_q;
         clk_16bd_q  <= clk_16bd;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         address_q   <= address_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // Counters are cleared on their terminal tick, so they never wrap in-state.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      byte_done   = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_prev_q && !rx_s_q) begin
               cnt_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (tick) begin
               if (cnt_q == MID_LAST) begin
                  cnt_d = '0;
                  if (!rx_s_q) begin
                     bit_idx_d = '0;
                     state_d   = DATA;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  shreg_d = {rx_s_q, shreg_q[7:1]};
                  if (bit_idx_q == 3'd7) state_d = STOP;
                  else bit_idx_d = bit_idx_q + 3'd1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d       = '0;
                  state_d     = IDLE;
                  byte_done   = rx_s_q;
                  frame_err_d = !rx_s_q;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // An ack landing on the completion cycle frees the slot for the new byte.
   always_comb begin
      address_d = address_q;
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      if (byte_done && (!valid_q || ack)) begin
         address_d = shreg_q[7:4];
         data_d    = shreg_q[3:0];
         valid_d   = 1'b1;
      end else if (byte_done) begin
         overrun_d = 1'b1;
      end else if (ack && valid_q) begin
         valid_d = 1'b0;
      end
   end

   assign address   = address_q;
   assign data      = data_q;
   assign valid     = valid_q;
   assign busy      = (state_q != IDLE);
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_cfg_rx.sv
// Scoreboard bench for uart_cfg_rx: expected requests are queued as bytes
// are sent and matched whenever the DUT presents a new request.
module tb_uart_cfg_rx;
   logic       clk = 1'b0, rst = 1'b0, clk_16bd = 1'b0, rx = 1'b1, ack = 1'b0;
   logic [3:0] address, data;
   logic       valid, busy, frame_err, overrun;

   int         n_chk = 0, n_bad = 0;
   int         fe_cnt = 0, ov_cnt = 0;
   logic [7:0] sb[$];
   logic       v_prev = 1'b0, fe_prev = 1'b0, ov_prev = 1'b0;
   logic [7:0] ad_prev = '0;

   uart_cfg_rx #(.OVERSAMPLE(16), .MID_SAMPLE(8)) dut (
      .clk(clk), .rst(rst), .clk_16bd(clk_16bd), .rx(rx), .ack(ack),
      .address(address), .data(data), .valid(valid), .busy(busy),
      .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;
   initial begin
      #2;
      forever #20 clk_16bd = ~clk_16bd;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // New request = valid rising, or held contents replaced (ack on completion).
   always @(negedge clk) begin
      if (!rst) begin
         v_prev  <= 1'b0;
         ad_prev <= '0;
         fe_prev <= 1'b0;
         ov_prev <= 1'b0;
      end else begin
         if (valid && (!v_prev || {address, data} != ad_prev)) begin
            if (sb.size() == 0) chk("unexp_req", 1, 0);
            else chk("req", {address, data}, sb.pop_front());
         end
         if (frame_err) begin
            chk("fe_1cyc", fe_prev, 0);
            fe_cnt <= fe_cnt + 1;
         end
         if (overrun) begin
            chk("ov_1cyc", ov_prev, 0);
            ov_cnt <= ov_cnt + 1;
         end
         v_prev  <= valid;
         ad_prev <= {address, data};
         fe_prev <= frame_err;
         ov_prev <= overrun;
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stopv);
      rx = 1'b0;
      #640;
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #640;
      end
      rx = stopv;
      #640;
   endtask

   task automatic ack_pulse();
      @(negedge clk) ack = 1'b1;
      @(negedge clk) ack = 1'b0;
   endtask

   initial begin
      int fe0, ov0;
      logic seen;
      logic [7:0] ab;
      ab = 8'hAB;

      // reset state
      #15;
      chk("rst_addr", address, 0);
      chk("rst_data", data, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fe", frame_err, 0);
      chk("rst_ov", overrun, 0);
      #5 rst = 1'b1;
      #200;

      // 1: basic byte, held until ack
      sb.push_back(8'h12);
      send_byte(8'h12, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t1_hold_valid", valid, 1);
      end
      chk("t1_addr", address, 4'h1);
      chk("t1_data", data, 4'h2);
      ack_pulse();
      chk("t1_ack_valid", valid, 0);
      chk("t1_ack_addr", address, 4'h1);
      chk("t1_ack_data", data, 4'h2);
      #200;

      // 2: start glitch
      fe0 = fe_cnt;
      seen = 1'b0;
      @(negedge clk) rx = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         seen |= busy;
      end
      rx = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         seen |= busy;
      end
      chk("t2_busy_seen", seen, 1);
      chk("t2_busy_off", busy, 0);
      chk("t2_valid", valid, 0);
      chk("t2_fe", fe_cnt - fe0, 0);

      // 3: framing error, then line stuck low
      fe0 = fe_cnt;
      send_byte(8'h9F, 1'b0);
      #1600;
      chk("t3_fe", fe_cnt - fe0, 1);
      chk("t3_valid", valid, 0);
      chk("t3_busy", busy, 0);
      rx = 1'b1;
      #400;
      chk("t3_valid_end", valid, 0);

      // 4: overrun
      ov0 = ov_cnt;
      sb.push_back(8'h91);
      send_byte(8'h91, 1'b1);
      #200;
      chk("t4_valid", valid, 1);
      chk("t4_addr", address, 4'h9);
      chk("t4_data", data, 4'h1);
      send_byte(8'h1F, 1'b1);
      #200;
      chk("t4_ov", ov_cnt - ov0, 1);
      chk("t4_keep_addr", address, 4'h9);
      chk("t4_keep_data", data, 4'h1);
      ack_pulse();
      sb.push_back(8'h1F);
      send_byte(8'h1F, 1'b1);
      #200;
      chk("t4_new_addr", address, 4'h1);
      chk("t4_new_data", data, 4'hF);

      // 5: reset during DATA bit 3
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      rx = 1'b0;
      #640;
      for (int i = 0; i < 3; i++) begin
         rx = ab[i];
         #640;
      end
      rx = ab[3];
      #320;
      rst = 1'b0;
      #1;
      chk("t5_addr", address, 0);
      chk("t5_data", data, 0);
      chk("t5_valid", valid, 0);
      chk("t5_busy", busy, 0);
      rx = 1'b1;
      #100 rst = 1'b1;
      #400;
      sb.push_back(8'h11);
      send_byte(8'h11, 1'b1);
      #200;
      chk("t5_new_addr", address, 4'h1);
      chk("t5_new_data", data, 4'h1);
      chk("t5_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

      // 6: ack on the completion cycle
      ack_pulse();
      #200;
      sb.push_back(8'h22);
      send_byte(8'h22, 1'b1);
      #200;
      chk("t6_hold", valid, 1);
      ov0 = ov_cnt;
      sb.push_back(8'h34);
      fork
         send_byte(8'h34, 1'b1);
         begin
            int w;
            w = 0;
            while (!busy && w < 100) begin
               @(negedge clk);
               w++;
            end
            chk("t6_busy_to", busy, 1);
            // stop sample lands on the edge after the 152nd tick rise
            repeat (152) @(posedge clk_16bd);
            ack = 1'b1;
            @(posedge clk);
            #1 ack = 1'b0;
            chk("t6_busy_fall", busy, 0);
            chk("t6_valid_edge", valid, 1);
         end
      join
      #200;
      chk("t6_valid", valid, 1);
      chk("t6_addr", address, 4'h3);
      chk("t6_data", data, 4'h4);
      chk("t6_ov", ov_cnt - ov0, 0);

      chk("sb_left", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
